// File: rtl/seg_pkg.sv
// Shared definitions for the pipeline segment register: NOP control
// constant, occupancy encoding and performance counter width/helpers.
package seg_pkg;

  // Widest control bundle the NOP constant covers; instances slice it down.
  localparam int SEG_CTRL_MAX_W = 64;

  // All-zero control is the pipeline bubble.
  localparam logic [SEG_CTRL_MAX_W-1:0] SEG_CTRL_NOP = {SEG_CTRL_MAX_W{1'b0}};

  // Number of held entries; doubles as the FSM state encoding.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } seg_occ_e;

  localparam int PERF_CNT_W = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_W-1:0] seg_sat_inc(input logic [PERF_CNT_W-1:0] v);
    logic [PERF_CNT_W-1:0] r;
    if (v == {PERF_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_perf_counter.sv
// Saturating event counter with increment enable. Used three times by
// seg_skid_reg when SEG_PERF_CNT_EN is defined.
module seg_perf_counter
  import seg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  output logic [PERF_CNT_W-1:0] count
);

  logic [PERF_CNT_W-1:0] count_r;

  // Count qualifying cycles, holding at the maximum value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {PERF_CNT_W{1'b0}};
    end else if (inc) begin
      count_r <= seg_sat_inc(count_r);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/seg_skid_reg.sv
// Generic pipeline segment register with valid/ready handshake and a
// two-entry skid buffer. in_ready comes straight from a flop, so
// downstream back-pressure never forms a combinational path upstream.
// Flush empties the buffer and zeroes stored control (and data when
// CLEAR_DATA=1). Optional macro SEG_PERF_CNT_EN adds stall, bubble and
// flush event counters without changing the datapath.
module seg_skid_reg
  import seg_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int CTRL_W     = 24,
  parameter int CLEAR_DATA = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [CTRL_W-1:0]     out_ctrl,
`ifdef SEG_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] bubble_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt,
`endif
  output logic [1:0]            occupancy
);

  localparam logic [CTRL_W-1:0] CTRL_NOP  = SEG_CTRL_NOP[CTRL_W-1:0];
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  seg_occ_e          occ_r,          occ_nxt_s;
  logic [DATA_W-1:0] main_data_r,    main_data_nxt_s;
  logic [CTRL_W-1:0] main_ctrl_r,    main_ctrl_nxt_s;
  logic [DATA_W-1:0] skid_data_r,    skid_data_nxt_s;
  logic [CTRL_W-1:0] skid_ctrl_r,    skid_ctrl_nxt_s;
  logic              in_ready_r,     in_ready_nxt_s;
  logic              out_valid_r,    out_valid_nxt_s;
  logic              accept_s;
  logic              pop_s;

  // Handshakes use only registered flags on our side.
  assign accept_s = in_valid & in_ready_r;
  assign pop_s    = out_valid_r & out_ready;

  // State and storage registers; in_ready/out_valid are registered copies
  // of the decoded next occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_r       <= OCC_EMPTY;
      main_data_r <= DATA_ZERO;
      main_ctrl_r <= CTRL_NOP;
      skid_data_r <= DATA_ZERO;
      skid_ctrl_r <= CTRL_NOP;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      occ_r       <= occ_nxt_s;
      main_data_r <= main_data_nxt_s;
      main_ctrl_r <= main_ctrl_nxt_s;
      skid_data_r <= skid_data_nxt_s;
      skid_ctrl_r <= skid_ctrl_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  // Next occupancy and storage: flush wins over accept, otherwise FIFO moves.
  always_comb begin
    occ_nxt_s       = occ_r;
    main_data_nxt_s = main_data_r;
    main_ctrl_nxt_s = main_ctrl_r;
    skid_data_nxt_s = skid_data_r;
    skid_ctrl_nxt_s = skid_ctrl_r;

    if (flush) begin
      occ_nxt_s       = OCC_EMPTY;
      main_ctrl_nxt_s = CTRL_NOP;
      skid_ctrl_nxt_s = CTRL_NOP;
      if (CLEAR_DATA != 0) begin
        main_data_nxt_s = DATA_ZERO;
        skid_data_nxt_s = DATA_ZERO;
      end else begin
        main_data_nxt_s = main_data_r;
        skid_data_nxt_s = skid_data_r;
      end
    end else begin
      case (occ_r)
        OCC_EMPTY: begin
          if (accept_s) begin
            occ_nxt_s       = OCC_ONE;
            main_data_nxt_s = in_data;
            main_ctrl_nxt_s = in_ctrl;
          end else begin
            occ_nxt_s = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (accept_s && pop_s) begin
            occ_nxt_s       = OCC_ONE;
            main_data_nxt_s = in_data;
            main_ctrl_nxt_s = in_ctrl;
          end else if (accept_s) begin
            occ_nxt_s       = OCC_TWO;
            skid_data_nxt_s = in_data;
            skid_ctrl_nxt_s = in_ctrl;
          end else if (pop_s) begin
            occ_nxt_s = OCC_EMPTY;
          end else begin
            occ_nxt_s = OCC_ONE;
          end
        end
        OCC_TWO: begin
          if (pop_s) begin
            occ_nxt_s       = OCC_ONE;
            main_data_nxt_s = skid_data_r;
            main_ctrl_nxt_s = skid_ctrl_r;
          end else begin
            occ_nxt_s = OCC_TWO;
          end
        end
        default: begin
          occ_nxt_s = OCC_EMPTY;
        end
      endcase
    end

    in_ready_nxt_s  = (occ_nxt_s != OCC_TWO);
    out_valid_nxt_s = (occ_nxt_s != OCC_EMPTY);
  end

  // Outputs: control is masked to NOP whenever the head is not valid.
  always_comb begin
    in_ready  = in_ready_r;
    out_valid = out_valid_r;
    out_data  = main_data_r;
    occupancy = occ_r;
    if (out_valid_r) begin
      out_ctrl = main_ctrl_r;
    end else begin
      out_ctrl = CTRL_NOP;
    end
  end

`ifdef SEG_PERF_CNT_EN
  logic stall_ev_s;
  logic bubble_ev_s;
  logic flush_ev_s;

  assign stall_ev_s  = in_valid & ~in_ready_r;
  assign bubble_ev_s = out_ready & ~out_valid_r;
  assign flush_ev_s  = flush & (occ_r != OCC_EMPTY);

  seg_perf_counter u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_ev_s),
    .count (stall_cnt)
  );

  seg_perf_counter u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble_ev_s),
    .count (bubble_cnt)
  );

  seg_perf_counter u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_ev_s),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_seg_skid_reg.sv
// Directed self-checking bench for seg_skid_reg (default parameters).
// Counter scenarios are compiled only when SEG_PERF_CNT_EN is defined.
module tb_seg_skid_reg;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 24;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
`ifdef SEG_PERF_CNT_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
  logic [31:0]       flush_cnt;
`endif

  int tests_run;
  int tests_failed;

  seg_skid_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
`ifdef SEG_PERF_CNT_EN
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt),
`endif
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample shortly after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data pattern tied to a control value so both fields can be checked.
  function automatic logic [DATA_W-1:0] pat(input logic [CTRL_W-1:0] c);
    return {32'hC0DE_0000, 72'h0, c};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_ctrl = 24'h00ABCD; in_data = pat(24'h00ABCD);
    out_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid cyc%0d got %b exp 0", i, out_valid); end
      tests_run++;
      if (out_ctrl !== 24'h0) begin tests_failed++; $display("FAIL reset_out_ctrl cyc%0d got %h exp 0", i, out_ctrl); end
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready cyc%0d got %b exp 1", i, in_ready); end
      tests_run++;
      if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL reset_occ cyc%0d got %0d exp 0", i, occupancy); end
    end
    tests_run++;
    if (out_data !== {DATA_W{1'b0}}) begin tests_failed++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    rst_n = 1'b1; in_valid = 1'b0; in_ctrl = 24'h0;
    tick();
    tests_run++;
    if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL post_reset_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_stream();
    logic [CTRL_W-1:0] c;
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      c = 24'(i);
      in_valid = 1'b1; in_ctrl = c; in_data = pat(c);
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_ctrl !== c) begin
        tests_failed++; $display("FAIL stream_head%0d got v=%b ctrl=%h exp v=1 ctrl=%h", i, out_valid, out_ctrl, c);
      end
      tests_run++;
      if (out_data !== pat(c)) begin tests_failed++; $display("FAIL stream_data%0d got %h exp %h", i, out_data, pat(c)); end
      tests_run++;
      if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
        tests_failed++; $display("FAIL stream_occ%0d got rdy=%b occ=%0d exp rdy=1 occ=1", i, in_ready, occupancy);
      end
    end
    // Garbage on the bus without in_valid must be ignored.
    in_valid = 1'b0; in_ctrl = 24'h0000FF; in_data = pat(24'h0000FF);
    tick();
    tests_run++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 24'h0) begin
      tests_failed++; $display("FAIL stream_drain got occ=%0d v=%b ctrl=%h exp 0/0/0", occupancy, out_valid, out_ctrl);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 24'h11; in_data = pat(24'h11);
    tick();
    tests_run++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_ctrl !== 24'h11) begin
      tests_failed++; $display("FAIL bp_first got occ=%0d rdy=%b ctrl=%h exp 1/1/11", occupancy, in_ready, out_ctrl);
    end
    in_ctrl = 24'h22; in_data = pat(24'h22);
    tick();
    tests_run++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_ctrl !== 24'h11) begin
      tests_failed++; $display("FAIL bp_full got occ=%0d rdy=%b ctrl=%h exp 2/0/11", occupancy, in_ready, out_ctrl);
    end
    in_ctrl = 24'h33; in_data = pat(24'h33);
    tick();
    tests_run++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_ctrl !== 24'h11) begin
      tests_failed++; $display("FAIL bp_hold got occ=%0d rdy=%b ctrl=%h exp 2/0/11", occupancy, in_ready, out_ctrl);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_ctrl !== 24'h22 || out_data !== pat(24'h22) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_second got ctrl=%h occ=%0d rdy=%b exp 22/1/1", out_ctrl, occupancy, in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_ctrl !== 24'h33 || out_data !== pat(24'h33) || occupancy !== 2'd1) begin
      tests_failed++; $display("FAIL bp_third got ctrl=%h occ=%0d exp 33/1", out_ctrl, occupancy);
    end
    tick();
    tests_run++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bp_drain got occ=%0d v=%b exp 0/0", occupancy, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 24'h55; in_data = pat(24'h55);
    tick();
    in_ctrl = 24'h66; in_data = pat(24'h66);
    tick();
    tests_run++;
    if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL flush_fill got occ=%0d exp 2", occupancy); end
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 24'h44; in_data = pat(24'h44);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_ctrl !== 24'h0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_empty got v=%b ctrl=%h occ=%0d rdy=%b exp 0/0/0/1", out_valid, out_ctrl, occupancy, in_ready);
    end
    tests_run++;
    if (out_data !== {DATA_W{1'b0}} || dut.skid_data_r !== {DATA_W{1'b0}}) begin
      tests_failed++; $display("FAIL flush_clear_data got main=%h skid=%h exp 0", out_data, dut.skid_data_r);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      tests_failed++; $display("FAIL flush_drop got v=%b occ=%0d ctrl=%h exp 0/0", out_valid, occupancy, out_ctrl);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 24'h88; in_data = pat(24'h88);
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_ctrl !== 24'h88) begin
      tests_failed++; $display("FAIL flush_recover got v=%b ctrl=%h exp 1/88", out_valid, out_ctrl);
    end
    tick();
  endtask

  task automatic test_flush_pop();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 24'h77; in_data = pat(24'h77);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1; flush = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_ctrl !== 24'h77 || occupancy !== 2'd1) begin
      tests_failed++; $display("FAIL fpop_head got v=%b ctrl=%h occ=%0d exp 1/77/1", out_valid, out_ctrl, occupancy);
    end
    tick();
    flush = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 24'h0) begin
      tests_failed++; $display("FAIL fpop_after got occ=%0d v=%b ctrl=%h exp 0/0/0", occupancy, out_valid, out_ctrl);
    end
  endtask

`ifdef SEG_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      tests_failed++; $display("FAIL perf_reset got %0d/%0d/%0d exp 0/0/0", stall_cnt, bubble_cnt, flush_cnt);
    end
    in_valid = 1'b1; in_ctrl = 24'h1; in_data = pat(24'h1);
    tick(); tick();
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b0;
    tests_run++;
    if (stall_cnt !== 32'd5) begin tests_failed++; $display("FAIL perf_stall got %0d exp 5", stall_cnt); end
    tests_run++;
    if (bubble_cnt !== 32'd3) begin tests_failed++; $display("FAIL perf_bubble got %0d exp 3", bubble_cnt); end
    tests_run++;
    if (flush_cnt !== 32'd1) begin tests_failed++; $display("FAIL perf_flush got %0d exp 1", flush_cnt); end
  endtask

  task automatic test_perf_sat();
    in_valid = 1'b1; out_ready = 1'b0;
    tick(); tick();
    force dut.u_stall_cnt.count_r = 32'hFFFF_FFFF;
    #1;
    release dut.u_stall_cnt.count_r;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL perf_sat got %h exp ffffffff", stall_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_flush_pop();
`ifdef SEG_PERF_CNT_EN
    test_perf();
    test_perf_sat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
